// File: rtl/sm_accumulator_if.sv
// ============================================================================
// Module   : sm_accumulator_if
// Purpose  : Operand-in / result-out handshake bundle for sm_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sm_accumulator_if #(
  parameter int N     = 5,
  parameter int CNT_W = 8
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] count;
  logic             ovflw;

  modport slave (
    input  clr, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, acc, count, ovflw
  );

  modport master (
    output clr, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, acc, count, ovflw
  );
endinterface

`default_nettype wire

// File: rtl/sm_accumulator.sv
// ============================================================================
// Module   : sm_accumulator
// Purpose  : Packet-based sign-magnitude accumulator with sticky overflow.
//            SM_ACC_SAT_EN: saturate magnitude on overflow (default: wrap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_accumulator #(
  parameter int N     = 5,
  parameter int CNT_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sm_accumulator_if.slave    bus
);

  localparam int M = N - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovflw;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [N-1:0]     w_opa;
  logic [M-1:0]     w_ma;
  logic [M-1:0]     w_mb;
  logic             w_sa;
  logic             w_sb;
  logic [M:0]       w_msum;
  logic [M-1:0]     w_mag;
  logic             w_sign;
  logic             w_ov;
  logic [N-1:0]     w_sum;
  logic             w_beat;
  logic [CNT_W-1:0] w_cnt_inc;

  // The first beat of a packet is added to +0, which also normalizes -0.
  assign w_opa  = (r_state == S_IDLE) ? '0 : r_acc;
  assign w_ma   = w_opa[M-1:0];
  assign w_mb   = bus.in_data[M-1:0];
  assign w_sa   = w_opa[N-1] & (|w_ma);
  assign w_sb   = bus.in_data[N-1] & (|w_mb);
  assign w_beat = bus.in_valid & r_in_ready;
  assign w_cnt_inc = (&r_count) ? r_count : r_count + CNT_W'(1);

  always_comb begin
    w_msum = {1'b0, w_ma} + {1'b0, w_mb};
    w_ov   = 1'b0;
    w_sign = w_sa;
    w_mag  = w_msum[M-1:0];
    if (w_sa == w_sb) begin
      w_ov = w_msum[M];
`ifdef SM_ACC_SAT_EN
      if (w_msum[M]) begin
        w_mag = '1;
      end
`endif
    end else if (w_ma >= w_mb) begin
      w_mag  = w_ma - w_mb;
      w_sign = w_sa;
    end else begin
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end
    w_sum = {w_sign & (|w_mag), w_mag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovflw     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.clr) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovflw     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          if (w_beat) begin
            r_acc   <= w_sum;
            r_count <= (r_state == S_IDLE) ? CNT_W'(1) : w_cnt_inc;
            r_ovflw <= (r_state == S_IDLE) ? 1'b0 : (r_ovflw | w_ov);
            if (bus.in_last) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.acc       = r_acc;
  assign bus.count     = r_count;
  assign bus.ovflw     = r_ovflw;

endmodule

`default_nettype wire

// File: tb/tb_sm_accumulator.sv
// ============================================================================
// Module   : tb_sm_accumulator
// Purpose  : Self-checking bench: vector table, corner sequences, random packets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_accumulator;

`ifdef SM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Reference state for the packet in progress
  logic [4:0] m_acc;
  int         m_cnt;
  bit         m_ov;
  bit         m_first;

  sm_accumulator_if #(.N(5), .CNT_W(8)) bus ();

  sm_accumulator #(.N(5), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][4:0] d;
    logic [2:0]      n;
    logic [4:0]      e_acc;
    logic [7:0]      e_cnt;
    logic            e_ov;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(input logic [4:0] d0, d1, d2, d3, input int n,
                              input logic [4:0] e_acc, input int e_cnt, input bit e_ov);
    vec_t v;
    v.d     = {d3, d2, d1, d0};
    v.n     = n[2:0];
    v.e_acc = e_acc;
    v.e_cnt = e_cnt[7:0];
    v.e_ov  = e_ov;
    return v;
  endfunction

  // Signed-integer view of sign-magnitude addition.
  function automatic void ref_add(input logic [4:0] a, input logic [4:0] b,
                                  output logic [4:0] r, output bit ov);
    int va, vb, s, mag;
    bit neg;
    va  = a[4] ? -int'(a[3:0]) : int'(a[3:0]);
    vb  = b[4] ? -int'(b[3:0]) : int'(b[3:0]);
    s   = va + vb;
    neg = (s < 0);
    mag = neg ? -s : s;
    ov  = 1'b0;
    if (mag > 15) begin
      ov  = 1'b1;
      mag = SAT ? 15 : (mag % 16);
    end
    if (mag == 0) neg = 1'b0;
    r = {neg, mag[3:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc   = 5'h00;
    m_cnt   = 0;
    m_ov    = 1'b0;
    m_first = 1'b1;
  endtask

  task automatic do_beat(input logic [4:0] d, input bit last);
    int         budget;
    logic [4:0] nacc;
    bit         nov;
    budget       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (m_first) begin
      ref_add(5'h00, d, nacc, nov);
      m_cnt = 1;
      m_ov  = 1'b0;
    end else begin
      ref_add(m_acc, d, nacc, nov);
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_ov  = m_ov | nov;
    end
    m_acc   = nacc;
    m_first = last;
    chk("beat_acc",       32'(bus.acc),       32'(m_acc));
    chk("beat_count",     32'(bus.count),     32'(m_cnt));
    chk("beat_ovflw",     32'(bus.ovflw),     32'(m_ov));
    chk("beat_out_valid", 32'(bus.out_valid), 32'(last));
  endtask

  task automatic drain(input int stall);
    chk("done_out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
      chk("stall_acc",       32'(bus.acc),       32'(m_acc));
      chk("stall_count",     32'(bus.count),     32'(m_cnt));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_in_ready",  32'(bus.in_ready),  32'd1);
    chk("idle_acc_kept",  32'(bus.acc),       32'(m_acc));
    chk("idle_cnt_kept",  32'(bus.count),     32'(m_cnt));
    chk("idle_ov_kept",   32'(bus.ovflw),     32'(m_ov));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 5'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    tbl[0] = mk(5'h03, 5'h05, 5'h12, 5'h00, 3, 5'h06, 3, 1'b0);
    tbl[1] = mk(5'h09, 5'h09, 5'h00, 5'h00, 2, SAT ? 5'h0F : 5'h02, 2, 1'b1);
    tbl[2] = mk(5'h14, 5'h04, 5'h00, 5'h00, 2, 5'h00, 2, 1'b0);
    tbl[3] = mk(5'h10, 5'h00, 5'h00, 5'h00, 1, 5'h00, 1, 1'b0);
    tbl[4] = mk(5'h0F, 5'h01, 5'h00, 5'h00, 2, SAT ? 5'h0F : 5'h00, 2, 1'b1);
    tbl[5] = mk(5'h18, 5'h18, 5'h00, 5'h00, 2, SAT ? 5'h1F : 5'h00, 2, 1'b1);
    tbl[6] = mk(5'h13, 5'h0A, 5'h1F, 5'h00, 3, 5'h18, 3, 1'b0);
    tbl[7] = mk(5'h0F, 5'h0F, 5'h1E, 5'h00, 3, SAT ? 5'h01 : 5'h00, 3, 1'b1);
    tbl[8] = mk(5'h11, 5'h12, 5'h13, 5'h01, 4, 5'h15, 4, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc",       32'(bus.acc),       32'd0);
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_ovflw",     32'(bus.ovflw),     32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b0;

    // Vector table
    for (int t = 0; t < 9; t++) begin
      for (int b = 0; b < int'(tbl[t].n); b++) begin
        do_beat(tbl[t].d[b], b == int'(tbl[t].n) - 1);
      end
      chk("tbl_acc",   32'(bus.acc),   32'(tbl[t].e_acc));
      chk("tbl_count", 32'(bus.count), 32'(tbl[t].e_cnt));
      chk("tbl_ovflw", 32'(bus.ovflw), 32'(tbl[t].e_ov));
      drain(t % 3);
    end

    // DONE holds with in_valid asserted and consumes nothing
    do_beat(5'h02, 1'b0);
    do_beat(5'h03, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 5'h01;
    drain(3);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("no_beat_in_done", 32'(bus.count), 32'd2);
    chk("no_beat_acc",     32'(bus.acc),   32'h05);

    // clr wins over a simultaneous beat
    do_beat(5'h07, 1'b0);
    do_beat(5'h13, 1'b0);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 5'h01;
    chk("clr_in_ready_pre", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    chk("clr_acc",       32'(bus.acc),       32'd0);
    chk("clr_count",     32'(bus.count),     32'd0);
    chk("clr_ovflw",     32'(bus.ovflw),     32'd0);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_in_ready",  32'(bus.in_ready),  32'd1);
    do_beat(5'h02, 1'b1);
    chk("clr_new_count", 32'(bus.count), 32'd1);
    chk("clr_new_acc",   32'(bus.acc),   32'h02);
    drain(0);

    // Asynchronous reset mid-packet
    do_beat(5'h05, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_acc",       32'(bus.acc),       32'd0);
    chk("arst_count",     32'(bus.count),     32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_beat(5'h06, 1'b1);
    chk("arst_new_count", 32'(bus.count), 32'd1);
    drain(1);

    // Beat counter saturation
    for (int i = 0; i < 300; i++) begin
      do_beat((i % 2 == 0) ? 5'h10 : 5'h00, i == 299);
    end
    chk("cnt_saturate", 32'(bus.count), 32'd255);
    drain(0);

    // Random packets against the reference model
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        do_beat(5'($urandom), b == len - 1);
      end
      drain($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
